// File: rtl/quote_generator_if.sv
// quote_generator_if: pair inputs, quote beat stream and status.
// master is the quote generator, slave is the upstream/downstream side.
interface quote_generator_if #(
  parameter int FP_WORD_SIZE = 64,
  parameter int DATA_WIDTH   = 32
);
  logic [FP_WORD_SIZE-1:0] i_spread;
  logic                    i_spread_valid;
  logic [FP_WORD_SIZE-1:0] i_res_price;
  logic                    i_res_price_valid;
  logic [DATA_WIDTH-1:0]   o_quote_price;
  logic                    o_quote_side;
  logic                    o_quote_valid;
  logic                    i_quote_ready;
  logic                    o_quote_dropped;
  logic                    o_busy;

  modport master (
    input  i_spread,
    input  i_spread_valid,
    input  i_res_price,
    input  i_res_price_valid,
    input  i_quote_ready,
    output o_quote_price,
    output o_quote_side,
    output o_quote_valid,
    output o_quote_dropped,
    output o_busy
  );

  modport slave (
    output i_spread,
    output i_spread_valid,
    output i_res_price,
    output i_res_price_valid,
    output i_quote_ready,
    input  o_quote_price,
    input  o_quote_side,
    input  o_quote_valid,
    input  o_quote_dropped,
    input  o_busy
  );
endinterface

// File: rtl/quote_generator.sv
// quote_generator: pairs spread and reservation price, quantizes to
// ticks, enforces min spread, filters repeats, emits bid then ask.
module quote_generator #(
  parameter int FP_WORD_SIZE     = 64,
  parameter int FRAC_BITS        = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int TICK_SHIFT       = 24,
  parameter int MIN_SPREAD_TICKS = 1
) (
  input logic i_clk,
  input logic i_rst_n,
  quote_generator_if.master q
);
  localparam int SW = FP_WORD_SIZE + 1;
  localparam int TW = FP_WORD_SIZE + 3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COMPUTE = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_BID     = 3'd3;
  localparam logic [2:0] S_ASK     = 3'd4;

  localparam logic signed [TW-1:0] ONE   = 1;
  localparam logic signed [TW-1:0] RND   = (ONE <<< TICK_SHIFT) - ONE;
  localparam logic signed [TW-1:0] MAX_T = (ONE <<< DATA_WIDTH) - ONE;
  localparam logic signed [TW-1:0] MIN_T = TW'(MIN_SPREAD_TICKS);

  logic [2:0] state;

  logic signed [FP_WORD_SIZE-1:0] spread_q;
  logic signed [FP_WORD_SIZE-1:0] price_q;
  logic signed [FP_WORD_SIZE-1:0] spread_s;
  logic signed [FP_WORD_SIZE-1:0] price_s;
  logic                           have_spread;
  logic                           have_price;

  logic signed [SW-1:0] bid_fp;
  logic signed [SW-1:0] ask_fp;

  logic [DATA_WIDTH-1:0] bid_q;
  logic [DATA_WIDTH-1:0] ask_q;
  logic [DATA_WIDTH-1:0] last_bid;
  logic [DATA_WIDTH-1:0] last_ask;
  logic                  last_valid;
  logic                  dropped;

  logic signed [FP_WORD_SIZE-1:0] half;
  logic signed [TW-1:0]           bid_x;
  logic signed [TW-1:0]           ask_x;
  logic signed [TW-1:0]           ask_r;
  logic signed [TW-1:0]           bid_t;
  logic signed [TW-1:0]           ask_t;
  logic                           out_range;
  logic                           dup;
  logic                           snap;

  assign snap = (state == S_IDLE) && have_spread && have_price;

  always_comb begin
    half  = spread_s >>> 1;
    bid_x = {{2{bid_fp[SW-1]}}, bid_fp};
    ask_x = {{2{ask_fp[SW-1]}}, ask_fp};
    ask_r = ask_x + RND;
    bid_t = bid_x >>> TICK_SHIFT;
    ask_t = ask_r >>> TICK_SHIFT;
    // also catches a crossed (negative-spread) pair
    if ((ask_t - bid_t) < MIN_T) begin
      ask_t = bid_t + MIN_T;
    end
    out_range = bid_t[TW-1] || (ask_t > MAX_T);
    dup = !out_range && last_valid
        && (bid_t[DATA_WIDTH-1:0] == last_bid)
        && (ask_t[DATA_WIDTH-1:0] == last_ask);
  end

  // a valid landing in the snapshot cycle keeps its flag set
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      spread_q    <= '0;
      price_q     <= '0;
      have_spread <= 1'b0;
      have_price  <= 1'b0;
    end else begin
      if (q.i_spread_valid) begin
        spread_q    <= q.i_spread;
        have_spread <= 1'b1;
      end else if (snap) begin
        have_spread <= 1'b0;
      end
      if (q.i_res_price_valid) begin
        price_q    <= q.i_res_price;
        have_price <= 1'b1;
      end else if (snap) begin
        have_price <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      spread_s   <= '0;
      price_s    <= '0;
      bid_fp     <= '0;
      ask_fp     <= '0;
      bid_q      <= '0;
      ask_q      <= '0;
      last_bid   <= '0;
      last_ask   <= '0;
      last_valid <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      dropped <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (snap) begin
            spread_s <= spread_q;
            price_s  <= price_q;
            state    <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          bid_fp <= {price_s[FP_WORD_SIZE-1], price_s}
                  - {half[FP_WORD_SIZE-1], half};
          ask_fp <= {price_s[FP_WORD_SIZE-1], price_s}
                  + {half[FP_WORD_SIZE-1], half};
          state  <= S_CHECK;
        end
        S_CHECK: begin
          unique case (1'b1)
            out_range: begin
              dropped <= 1'b1;
              state   <= S_IDLE;
            end
            dup: begin
              state <= S_IDLE;
            end
            default: begin
              bid_q <= bid_t[DATA_WIDTH-1:0];
              ask_q <= ask_t[DATA_WIDTH-1:0];
              state <= S_BID;
            end
          endcase
        end
        S_BID: begin
          if (q.i_quote_ready) begin
            state <= S_ASK;
          end
        end
        S_ASK: begin
          if (q.i_quote_ready) begin
            last_bid   <= bid_q;
            last_ask   <= ask_q;
            last_valid <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign q.o_quote_valid   = (state == S_BID) || (state == S_ASK);
  assign q.o_quote_side    = (state == S_ASK);
  assign q.o_quote_price   = (state == S_ASK) ? ask_q
                           : (state == S_BID) ? bid_q
                           : '0;
  assign q.o_quote_dropped = dropped;
  assign q.o_busy          = (state != S_IDLE);

endmodule

// File: tb/tb_quote_generator.sv
// tb_quote_generator: directed timing cases plus randomized pairs
// scored against an arithmetic floor/ceil model of the quote rules.
module tb_quote_generator;
  localparam int FW   = 64;
  localparam int DW   = 32;
  localparam int TS   = 24;
  localparam int MINS = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  quote_generator_if #(.FP_WORD_SIZE(FW), .DATA_WIDTH(DW)) qif();

  quote_generator #(
    .FP_WORD_SIZE(FW), .FRAC_BITS(32), .DATA_WIDTH(DW),
    .TICK_SHIFT(TS), .MIN_SPREAD_TICKS(MINS)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .q(qif)
  );

  int total = 0;
  int bad = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  int          drop_cnt = 0;
  int          exp_drops = 0;
  bit          last_ok = 1'b0;
  longint      last_b = 0;
  longint      last_a = 0;

  function automatic longint fx(int units);
    return longint'(units) <<< 32;
  endfunction

  function automatic longint fdiv(longint a, longint d);
    longint r = a / d;
    if ((a % d != 0) && (a < 0)) r -= 1;
    return r;
  endfunction

  function automatic longint cdiv(longint a, longint d);
    longint r = a / d;
    if ((a % d != 0) && (a > 0)) r += 1;
    return r;
  endfunction

  task automatic model_push(longint r, longint s);
    longint h, bt, at, tick_sz, maxp;
    tick_sz = longint'(1) <<< TS;
    maxp = (longint'(1) <<< DW) - 1;
    h  = fdiv(s, 2);
    bt = fdiv(r - h, tick_sz);
    at = cdiv(r + h, tick_sz);
    if (at - bt < MINS) at = bt + MINS;
    if (bt < 0 || at > maxp) begin
      exp_drops++;
    end else if (!(last_ok && bt == last_b && at == last_a)) begin
      exp_q.push_back({1'b0, bt[31:0]});
      exp_q.push_back({1'b1, at[31:0]});
      last_ok = 1'b1;
      last_b = bt;
      last_a = at;
    end
  endtask

  bit          hold = 1'b0;
  logic [32:0] hold_beat;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", qif.o_quote_valid, 1);
        check("hold_beat", {qif.o_quote_side, qif.o_quote_price}, hold_beat);
      end
      if (qif.o_quote_valid && qif.i_quote_ready)
        got_q.push_back({qif.o_quote_side, qif.o_quote_price});
      if (qif.o_quote_dropped) drop_cnt++;
      hold = qif.o_quote_valid && !qif.i_quote_ready;
      hold_beat = {qif.o_quote_side, qif.o_quote_price};
    end
  end

  bit rnd_rdy = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) qif.i_quote_ready = ($urandom_range(3) != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(longint r, longint s);
    qif.i_res_price = r;
    qif.i_spread = s;
    qif.i_res_price_valid = 1'b1;
    qif.i_spread_valid = 1'b1;
    tick();
    qif.i_res_price_valid = 1'b0;
    qif.i_spread_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    int idle = 0;
    while (idle < 3 && n < 300) begin
      tick();
      n++;
      if (!qif.o_busy) idle++;
      else idle = 0;
    end
    if (n >= 300) check("idle_timeout", n, 0);
  endtask

  task automatic check_all(string tag);
    check({tag, "_n"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_beat"}, got_q[i], exp_q[i]);
    check({tag, "_drop"}, drop_cnt, exp_drops);
    got_q.delete();
    exp_q.delete();
    drop_cnt = 0;
    exp_drops = 0;
  endtask

  initial begin
    longint r, s;
    qif.i_spread = '0;
    qif.i_res_price = '0;
    qif.i_spread_valid = 1'b0;
    qif.i_res_price_valid = 1'b0;
    qif.i_quote_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_valid", qif.o_quote_valid, 0);
    check("rst_price", qif.o_quote_price, 0);
    check("rst_side", qif.o_quote_side, 0);
    check("rst_drop", qif.o_quote_dropped, 0);
    check("rst_busy", qif.o_busy, 0);
    rst_n = 1'b1;
    tick();

    qif.i_quote_ready = 1'b1;
    send(fx(100), fx(1));
    check("t1_busy", qif.o_busy, 0);
    tick();
    check("t2_busy", qif.o_busy, 1);
    tick();
    check("t3_valid", qif.o_quote_valid, 0);
    tick();
    check("t4_valid", qif.o_quote_valid, 1);
    check("t4_side", qif.o_quote_side, 0);
    check("t4_price", qif.o_quote_price, 25472);
    tick();
    check("t5_valid", qif.o_quote_valid, 1);
    check("t5_side", qif.o_quote_side, 1);
    check("t5_price", qif.o_quote_price, 25728);
    tick();
    check("t6_busy", qif.o_busy, 0);
    model_push(fx(100), fx(1));
    wait_idle();
    check_all("basic");

    send(fx(100), 64'h0080_0000);
    model_push(fx(100), 64'h0080_0000);
    wait_idle();
    check_all("round");

    send(fx(100), 0);
    model_push(fx(100), 0);
    wait_idle();
    check_all("min0");

    send(fx(100), -fx(1));
    model_push(fx(100), -fx(1));
    wait_idle();
    check_all("minneg");

    qif.i_quote_ready = 1'b0;
    send(fx(100), fx(1));
    model_push(fx(100), fx(1));
    tick();
    tick();
    tick();
    check("bp_valid", qif.o_quote_valid, 1);
    check("bp_price", qif.o_quote_price, 25472);
    send(fx(101), fx(1));
    tick();
    qif.i_res_price = fx(102);
    qif.i_res_price_valid = 1'b1;
    tick();
    qif.i_res_price_valid = 1'b0;
    check("bp_hold_side", qif.o_quote_side, 0);
    check("bp_hold_price", qif.o_quote_price, 25472);
    model_push(fx(102), fx(1));
    qif.i_quote_ready = 1'b1;
    wait_idle();
    check_all("bp");

    send(fx(100), fx(1));
    model_push(fx(100), fx(1));
    wait_idle();
    check_all("resend");
    send(fx(100), fx(1));
    model_push(fx(100), fx(1));
    wait_idle();
    check_all("dup");

    send(64'h4000_0000, fx(1));
    model_push(64'h4000_0000, fx(1));
    wait_idle();
    check_all("drop");
    send(fx(100), fx(1));
    model_push(fx(100), fx(1));
    wait_idle();
    check_all("dup_after_drop");

    qif.i_quote_ready = 1'b0;
    send(fx(50), fx(2));
    tick();
    tick();
    tick();
    check("rq_bid_valid", qif.o_quote_valid, 1);
    qif.i_quote_ready = 1'b1;
    tick();
    qif.i_quote_ready = 1'b0;
    check("rq_ask_side", qif.o_quote_side, 1);
    check("rq_ask_valid", qif.o_quote_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rq_valid_drop", qif.o_quote_valid, 0);
    check("rq_busy", qif.o_busy, 0);
    check("rq_orphan", got_q.size(), 1);
    got_q.delete();
    last_ok = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    qif.i_quote_ready = 1'b1;
    send(fx(50), fx(2));
    model_push(fx(50), fx(2));
    wait_idle();
    check_all("rq_again");

    rnd_rdy = 1'b1;
    r = fx(10);
    s = fx(1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) != 0) begin
        case ($urandom_range(3))
          0, 1: r = longint'($urandom_range(32'hFF_FFFF)) <<< 16;
          2: r = -longint'($urandom);
          default: r = (longint'(1) <<< 56) - (longint'($urandom) <<< 8);
        endcase
        s = longint'($signed($urandom)) <<< $urandom_range(4);
      end
      send(r, s);
      model_push(r, s);
      wait_idle();
      check_all("rnd");
    end
    rnd_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
